// File: rtl/control_sequencer_pkg.sv
// Shared opcodes, ALU function codes, instruction classes, FSM state codes and the
// datapath control word driven by the Mini SRC control sequencer.
package control_pkg;

    localparam int unsigned OP_LD   = 0;
    localparam int unsigned OP_LDI  = 1;
    localparam int unsigned OP_ST   = 2;
    localparam int unsigned OP_ADD  = 3;
    localparam int unsigned OP_SUB  = 4;
    localparam int unsigned OP_AND  = 5;
    localparam int unsigned OP_OR   = 6;
    localparam int unsigned OP_SHR  = 7;
    localparam int unsigned OP_SHRA = 8;
    localparam int unsigned OP_SHL  = 9;
    localparam int unsigned OP_ROR  = 10;
    localparam int unsigned OP_ROL  = 11;
    localparam int unsigned OP_ADDI = 12;
    localparam int unsigned OP_ANDI = 13;
    localparam int unsigned OP_ORI  = 14;
    localparam int unsigned OP_MUL  = 15;
    localparam int unsigned OP_DIV  = 16;
    localparam int unsigned OP_NEG  = 17;
    localparam int unsigned OP_NOT  = 18;
    localparam int unsigned OP_BR   = 19;
    localparam int unsigned OP_JR   = 20;
    localparam int unsigned OP_JAL  = 21;
    localparam int unsigned OP_IN   = 22;
    localparam int unsigned OP_OUT  = 23;
    localparam int unsigned OP_MFHI = 24;
    localparam int unsigned OP_MFLO = 25;
    localparam int unsigned OP_NOP  = 26;
    localparam int unsigned OP_HALT = 27;

    typedef enum logic [3:0] {
        ALU_NONE = 4'd0,
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_AND  = 4'd3,
        ALU_OR   = 4'd4,
        ALU_SHR  = 4'd5,
        ALU_SHRA = 4'd6,
        ALU_SHL  = 4'd7,
        ALU_ROR  = 4'd8,
        ALU_ROL  = 4'd9,
        ALU_MUL  = 4'd10,
        ALU_DIV  = 4'd11,
        ALU_NEG  = 4'd12,
        ALU_NOT  = 4'd13
    } alu_op_t;

    typedef enum logic [4:0] {
        CL_ALU, CL_IMM, CL_LD, CL_LDI, CL_ST, CL_MD, CL_UNARY, CL_BR, CL_JR,
        CL_JAL, CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_NOP, CL_HALT, CL_ILL
    } instr_cls_t;

    typedef logic [3:0] state_t;

    localparam state_t S_INIT     = 4'd0;
    localparam state_t S_T0       = 4'd1;
    localparam state_t S_T1       = 4'd2;
    localparam state_t S_T2       = 4'd3;
    localparam state_t S_T3       = 4'd4;
    localparam state_t S_T4       = 4'd5;
    localparam state_t S_T5       = 4'd6;
    localparam state_t S_T6       = 4'd7;
    localparam state_t S_T7       = 4'd8;
    localparam state_t S_WAIT_MEM = 4'd9;
    localparam state_t S_WAIT_MD  = 4'd10;
    localparam state_t S_PAUSE    = 4'd11;
    localparam state_t S_HALT     = 4'd12;

    typedef struct packed {
        logic    rin;
        logic    hiin;
        logic    loin;
        logic    conin;
        logic    pcin;
        logic    irin;
        logic    yin;
        logic    zin;
        logic    marin;
        logic    mdrin;
        logic    outport_in;
        logic    rout;
        logic    baout;
        logic    cout;
        logic    pcout;
        logic    mdrout;
        logic    zhiout;
        logic    zloout;
        logic    hiout;
        logic    loout;
        logic    inport_out;
        logic    gra;
        logic    grb;
        logic    grc;
        logic    rlink;
        logic    incpc;
        logic    alu_start;
        logic    read;
        logic    write;
        alu_op_t alu_op;
    } ctrl_t;

endpackage

// File: rtl/control_sequencer_if.sv
// Control word from the sequencer to the datapath plus the memory and mul/div
// completion handshakes coming back.
interface control_sequencer_if;
    import control_pkg::*;

    ctrl_t ctl;
    logic  mem_ready;
    logic  alu_done;

    modport master (output ctl, input mem_ready, input alu_done);
    modport slave (input ctl, output mem_ready, output alu_done);

endinterface

// File: rtl/control_sequencer_decode.sv
// Combinational opcode decode: instruction class and ALU function for the execute phase.
module cs_decode
    import control_pkg::*;
#(
    parameter int unsigned OPC_W = 5
) (
    input  logic [OPC_W-1:0] i_opc,
    output instr_cls_t       o_cls,
    output alu_op_t          o_alu_op
);

    logic [31:0] w_opc;

    assign w_opc = 32'(i_opc);

    always_comb begin
        o_cls    = CL_ILL;
        o_alu_op = ALU_NONE;
        case (w_opc)
            OP_LD:   begin o_cls = CL_LD;    o_alu_op = ALU_ADD;  end
            OP_LDI:  begin o_cls = CL_LDI;   o_alu_op = ALU_ADD;  end
            OP_ST:   begin o_cls = CL_ST;    o_alu_op = ALU_ADD;  end
            OP_ADD:  begin o_cls = CL_ALU;   o_alu_op = ALU_ADD;  end
            OP_SUB:  begin o_cls = CL_ALU;   o_alu_op = ALU_SUB;  end
            OP_AND:  begin o_cls = CL_ALU;   o_alu_op = ALU_AND;  end
            OP_OR:   begin o_cls = CL_ALU;   o_alu_op = ALU_OR;   end
            OP_SHR:  begin o_cls = CL_ALU;   o_alu_op = ALU_SHR;  end
            OP_SHRA: begin o_cls = CL_ALU;   o_alu_op = ALU_SHRA; end
            OP_SHL:  begin o_cls = CL_ALU;   o_alu_op = ALU_SHL;  end
            OP_ROR:  begin o_cls = CL_ALU;   o_alu_op = ALU_ROR;  end
            OP_ROL:  begin o_cls = CL_ALU;   o_alu_op = ALU_ROL;  end
            OP_ADDI: begin o_cls = CL_IMM;   o_alu_op = ALU_ADD;  end
            OP_ANDI: begin o_cls = CL_IMM;   o_alu_op = ALU_AND;  end
            OP_ORI:  begin o_cls = CL_IMM;   o_alu_op = ALU_OR;   end
            OP_MUL:  begin o_cls = CL_MD;    o_alu_op = ALU_MUL;  end
            OP_DIV:  begin o_cls = CL_MD;    o_alu_op = ALU_DIV;  end
            OP_NEG:  begin o_cls = CL_UNARY; o_alu_op = ALU_NEG;  end
            OP_NOT:  begin o_cls = CL_UNARY; o_alu_op = ALU_NOT;  end
            OP_BR:   begin o_cls = CL_BR;    o_alu_op = ALU_ADD;  end
            OP_JR:   o_cls = CL_JR;
            OP_JAL:  o_cls = CL_JAL;
            OP_IN:   o_cls = CL_IN;
            OP_OUT:  o_cls = CL_OUT;
            OP_MFHI: o_cls = CL_MFHI;
            OP_MFLO: o_cls = CL_MFLO;
            OP_NOP:  o_cls = CL_NOP;
            OP_HALT: o_cls = CL_HALT;
            default: o_cls = CL_ILL;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired T-state control unit for the Mini SRC datapath with memory and mul/div
// stalls, pause/halt control and sticky illegal-opcode trapping.
module control_sequencer
    import control_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned OPC_W      = 5,
    parameter int unsigned MEM_HS     = 1,
    parameter int unsigned MULDIV_HS  = 1,
    parameter int unsigned MULDIV_CYC = 32
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_stop,
    input  logic                i_con_ff,
    input  logic [DATA_W-1:0]   i_ir,
    control_sequencer_if.master bus,
    output logic                o_run,
    output logic                o_clear,
    output logic                o_illegal
);

    state_t     r_state;
    state_t     r_mem_state;
    state_t     w_next;
    state_t     w_eff;
    state_t     w_bnd;
    instr_cls_t r_cls;
    instr_cls_t w_dec_cls;
    alu_op_t    r_alu;
    alu_op_t    w_dec_alu;
    logic [31:0] r_md_cnt;
    logic       r_illegal;
    logic       w_mem_ok;
    logic       w_md_done;
    logic       w_unused_ir;
    ctrl_t      w_ctl;

    cs_decode #(
        .OPC_W (OPC_W)
    ) u_decode (
        .i_opc    (i_ir[DATA_W-1 -: OPC_W]),
        .o_cls    (w_dec_cls),
        .o_alu_op (w_dec_alu)
    );

    assign w_unused_ir = ^i_ir[DATA_W-OPC_W-1:0];

    assign w_mem_ok  = (MEM_HS == 0) || bus.mem_ready;
    assign w_md_done = (MULDIV_HS != 0) ? bus.alu_done : (r_md_cnt == MULDIV_CYC - 1);

    // A memory stall reuses the stalled T-state for both next-state and strobe decode.
    assign w_eff = (r_state == S_WAIT_MEM) ? r_mem_state : r_state;
    assign w_bnd = i_stop ? S_PAUSE : S_T0;

    always_comb begin
        w_next = r_state;
        case (w_eff)
            S_INIT: w_next = S_T0;
            S_T0:   w_next = S_T1;
            S_T1:   w_next = w_mem_ok ? S_T2 : S_WAIT_MEM;
            S_T2: begin
                case (w_dec_cls)
                    CL_NOP, CL_ILL: w_next = w_bnd;
                    CL_HALT:        w_next = S_HALT;
                    default:        w_next = S_T3;
                endcase
            end
            S_T3: begin
                case (r_cls)
                    CL_JR, CL_IN, CL_OUT, CL_MFHI, CL_MFLO: w_next = w_bnd;
                    default:                                w_next = S_T4;
                endcase
            end
            S_T4: begin
                case (r_cls)
                    CL_UNARY, CL_JAL: w_next = w_bnd;
                    CL_MD: w_next = ((MULDIV_HS != 0) && bus.alu_done) ? S_T5 : S_WAIT_MD;
                    default:          w_next = S_T5;
                endcase
            end
            S_T5: begin
                case (r_cls)
                    CL_ALU, CL_IMM, CL_LDI: w_next = w_bnd;
                    default:                w_next = S_T6;
                endcase
            end
            S_T6: begin
                case (r_cls)
                    CL_LD:   w_next = w_mem_ok ? S_T7 : S_WAIT_MEM;
                    CL_ST:   w_next = S_T7;
                    default: w_next = w_bnd;
                endcase
            end
            S_T7: begin
                if (r_cls == CL_ST) begin
                    w_next = w_mem_ok ? w_bnd : S_WAIT_MEM;
                end else begin
                    w_next = w_bnd;
                end
            end
            S_WAIT_MD: if (w_md_done) w_next = S_T5;
            S_PAUSE:   if (!i_stop) w_next = S_T0;
            S_HALT:    w_next = S_HALT;
            default:   w_next = S_INIT;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_INIT;
            r_mem_state <= S_T1;
            r_cls       <= CL_NOP;
            r_alu       <= ALU_NONE;
            r_md_cnt    <= '0;
            r_illegal   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state != S_WAIT_MEM) begin
                r_mem_state <= r_state;
            end
            if (w_eff == S_T2) begin
                r_cls <= w_dec_cls;
                r_alu <= w_dec_alu;
                if (w_dec_cls == CL_ILL) begin
                    r_illegal <= 1'b1;
                end
            end
            if (r_state == S_WAIT_MD) begin
                r_md_cnt <= r_md_cnt + 32'd1;
            end else begin
                r_md_cnt <= '0;
            end
        end
    end

    always_comb begin
        w_ctl = '0;
        case (w_eff)
            S_T0: begin
                w_ctl.pcout = 1'b1; w_ctl.marin = 1'b1; w_ctl.incpc = 1'b1; w_ctl.zin = 1'b1;
            end
            S_T1: begin
                w_ctl.zloout = 1'b1; w_ctl.pcin = 1'b1; w_ctl.read = 1'b1; w_ctl.mdrin = 1'b1;
            end
            S_T2: begin
                w_ctl.mdrout = 1'b1; w_ctl.irin = 1'b1;
            end
            S_T3: begin
                case (r_cls)
                    CL_ALU, CL_IMM: begin
                        w_ctl.grb = 1'b1; w_ctl.rout = 1'b1; w_ctl.yin = 1'b1;
                    end
                    CL_LD, CL_LDI, CL_ST: begin
                        w_ctl.grb = 1'b1; w_ctl.baout = 1'b1; w_ctl.yin = 1'b1;
                    end
                    CL_MD: begin
                        w_ctl.gra = 1'b1; w_ctl.rout = 1'b1; w_ctl.yin = 1'b1;
                    end
                    CL_UNARY: begin
                        w_ctl.grb = 1'b1; w_ctl.rout = 1'b1; w_ctl.alu_op = r_alu;
                        w_ctl.zin = 1'b1;
                    end
                    CL_BR: begin
                        w_ctl.gra = 1'b1; w_ctl.rout = 1'b1; w_ctl.conin = 1'b1;
                    end
                    CL_JR: begin
                        w_ctl.gra = 1'b1; w_ctl.rout = 1'b1; w_ctl.pcin = 1'b1;
                    end
                    CL_JAL: begin
                        w_ctl.pcout = 1'b1; w_ctl.rlink = 1'b1; w_ctl.rin = 1'b1;
                    end
                    CL_IN: begin
                        w_ctl.inport_out = 1'b1; w_ctl.gra = 1'b1; w_ctl.rin = 1'b1;
                    end
                    CL_OUT: begin
                        w_ctl.gra = 1'b1; w_ctl.rout = 1'b1; w_ctl.outport_in = 1'b1;
                    end
                    CL_MFHI: begin
                        w_ctl.hiout = 1'b1; w_ctl.gra = 1'b1; w_ctl.rin = 1'b1;
                    end
                    CL_MFLO: begin
                        w_ctl.loout = 1'b1; w_ctl.gra = 1'b1; w_ctl.rin = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                case (r_cls)
                    CL_ALU: begin
                        w_ctl.grc = 1'b1; w_ctl.rout = 1'b1; w_ctl.alu_op = r_alu;
                        w_ctl.zin = 1'b1;
                    end
                    CL_IMM, CL_LD, CL_LDI, CL_ST: begin
                        w_ctl.cout = 1'b1; w_ctl.alu_op = r_alu; w_ctl.zin = 1'b1;
                    end
                    CL_MD: begin
                        w_ctl.grb = 1'b1; w_ctl.rout = 1'b1; w_ctl.alu_op = r_alu;
                        w_ctl.zin = 1'b1; w_ctl.alu_start = 1'b1;
                    end
                    CL_UNARY: begin
                        w_ctl.zloout = 1'b1; w_ctl.gra = 1'b1; w_ctl.rin = 1'b1;
                    end
                    CL_BR: begin
                        w_ctl.pcout = 1'b1; w_ctl.yin = 1'b1;
                    end
                    CL_JAL: begin
                        w_ctl.gra = 1'b1; w_ctl.rout = 1'b1; w_ctl.pcin = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                case (r_cls)
                    CL_ALU, CL_IMM, CL_LDI: begin
                        w_ctl.zloout = 1'b1; w_ctl.gra = 1'b1; w_ctl.rin = 1'b1;
                    end
                    CL_LD, CL_ST: begin
                        w_ctl.zloout = 1'b1; w_ctl.marin = 1'b1;
                    end
                    CL_MD: begin
                        w_ctl.zloout = 1'b1; w_ctl.loin = 1'b1;
                    end
                    CL_BR: begin
                        w_ctl.cout = 1'b1; w_ctl.alu_op = r_alu; w_ctl.zin = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                case (r_cls)
                    CL_LD: begin
                        w_ctl.read = 1'b1; w_ctl.mdrin = 1'b1;
                    end
                    CL_ST: begin
                        w_ctl.gra = 1'b1; w_ctl.rout = 1'b1; w_ctl.mdrin = 1'b1;
                    end
                    CL_MD: begin
                        w_ctl.zhiout = 1'b1; w_ctl.hiin = 1'b1;
                    end
                    CL_BR: begin
                        w_ctl.zloout = 1'b1; w_ctl.pcin = i_con_ff;
                    end
                    default: ;
                endcase
            end
            S_T7: begin
                case (r_cls)
                    CL_LD: begin
                        w_ctl.mdrout = 1'b1; w_ctl.gra = 1'b1; w_ctl.rin = 1'b1;
                    end
                    CL_ST:   w_ctl.write = 1'b1;
                    default: ;
                endcase
            end
            S_WAIT_MD: w_ctl.alu_op = r_alu;
            default: ;
        endcase
    end

    assign bus.ctl   = w_ctl;
    assign o_run     = (r_state != S_PAUSE) && (r_state != S_HALT);
    assign o_clear   = (r_state == S_INIT) && !i_reset;
    assign o_illegal = r_illegal;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: fetch/execute strobes, stalls, pause, halt,
// illegal trapping and reset abort, against hand-written expected control words.
module tb_control_sequencer;
    import control_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        stop;
    logic        con_ff;
    logic [31:0] ir;
    logic        run;
    logic        clear;
    logic        illegal;
    int          n_checks = 0;
    int          n_fail = 0;

    control_sequencer_if bus ();

    control_sequencer #(
        .DATA_W     (32),
        .OPC_W      (5),
        .MEM_HS     (1),
        .MULDIV_HS  (0),
        .MULDIV_CYC (32)
    ) dut (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_stop    (stop),
        .i_con_ff  (con_ff),
        .i_ir      (ir),
        .bus       (bus),
        .o_run     (run),
        .o_clear   (clear),
        .o_illegal (illegal)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, required %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input ctrl_t exp);
        tick();
        check_eq(tag, 64'(bus.ctl), 64'(exp));
    endtask

    function automatic ctrl_t t0_exp();
        ctrl_t e = '0;
        e.pcout = 1'b1; e.marin = 1'b1; e.incpc = 1'b1; e.zin = 1'b1;
        return e;
    endfunction

    function automatic ctrl_t t1_exp();
        ctrl_t e = '0;
        e.zloout = 1'b1; e.pcin = 1'b1; e.read = 1'b1; e.mdrin = 1'b1;
        return e;
    endfunction

    function automatic ctrl_t t2_exp();
        ctrl_t e = '0;
        e.mdrout = 1'b1; e.irin = 1'b1;
        return e;
    endfunction

    // Entered in T0; leaves the bench sampling inside T2.
    task automatic fetch(input string tag, input logic [4:0] opc);
        ir = {opc, 27'd0};
        check_eq({tag, "_t0"}, 64'(bus.ctl), 64'(t0_exp()));
        step({tag, "_t1"}, t1_exp());
        step({tag, "_t2"}, t2_exp());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion, required completion");
        $fatal(1, "bench timed out");
    end

    initial begin
        ctrl_t e;
        ctrl_t e_read;
        int    n;
        int    starts;

        reset = 1'b1; stop = 1'b0; con_ff = 1'b0; ir = '0;
        bus.mem_ready = 1'b1; bus.alu_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ctl", 64'(bus.ctl), 64'(0));
        check_eq("rst_run", 64'(run), 64'(1));
        check_eq("rst_clear", 64'(clear), 64'(0));
        check_eq("rst_illegal", 64'(illegal), 64'(0));
        reset = 1'b0;
        #1;
        check_eq("init_clear", 64'(clear), 64'(1));
        tick();

        // add R1,R2,R3
        fetch("add", 5'(OP_ADD));
        e = '0; e.grb = 1'b1; e.rout = 1'b1; e.yin = 1'b1; step("add_t3", e);
        e = '0; e.grc = 1'b1; e.rout = 1'b1; e.alu_op = ALU_ADD; e.zin = 1'b1; step("add_t4", e);
        e = '0; e.zloout = 1'b1; e.gra = 1'b1; e.rin = 1'b1; step("add_t5", e);
        step("add_back_t0", t0_exp());

        // ld with memory stalled at T6
        fetch("ld", 5'(OP_LD));
        e = '0; e.grb = 1'b1; e.baout = 1'b1; e.yin = 1'b1; step("ld_t3", e);
        e = '0; e.cout = 1'b1; e.alu_op = ALU_ADD; e.zin = 1'b1; step("ld_t4", e);
        e = '0; e.zloout = 1'b1; e.marin = 1'b1; step("ld_t5", e);
        e_read = '0; e_read.read = 1'b1; e_read.mdrin = 1'b1;
        step("ld_t6_c1", e_read);
        bus.mem_ready = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            tick();
            if (i == 4) bus.mem_ready = 1'b1;
            check_eq("ld_t6_hold", 64'(bus.ctl), 64'(e_read));
        end
        e = '0; e.mdrout = 1'b1; e.gra = 1'b1; e.rin = 1'b1; step("ld_t7", e);
        step("ld_back_t0", t0_exp());

        // mul with fixed 32-cycle latency
        fetch("mul", 5'(OP_MUL));
        e = '0; e.gra = 1'b1; e.rout = 1'b1; e.yin = 1'b1; step("mul_t3", e);
        e = '0; e.grb = 1'b1; e.rout = 1'b1; e.alu_op = ALU_MUL; e.zin = 1'b1;
        e.alu_start = 1'b1; step("mul_t4", e);
        e = '0; e.alu_op = ALU_MUL; step("mul_wait", e);
        n = 1; starts = 0;
        while (!bus.ctl.loin && n < 100) begin
            tick();
            n++;
            if (bus.ctl.alu_start) starts++;
        end
        check_eq("mul_latency", 64'(n), 64'(33));
        check_eq("mul_start_pulses", 64'(starts), 64'(0));
        e = '0; e.zloout = 1'b1; e.loin = 1'b1;
        check_eq("mul_t5", 64'(bus.ctl), 64'(e));
        e = '0; e.zhiout = 1'b1; e.hiin = 1'b1; step("mul_t6", e);
        step("mul_back_t0", t0_exp());

        // br not taken then taken
        con_ff = 1'b0;
        fetch("br0", 5'(OP_BR));
        e = '0; e.gra = 1'b1; e.rout = 1'b1; e.conin = 1'b1; step("br0_t3", e);
        e = '0; e.pcout = 1'b1; e.yin = 1'b1; step("br0_t4", e);
        e = '0; e.cout = 1'b1; e.alu_op = ALU_ADD; e.zin = 1'b1; step("br0_t5", e);
        e = '0; e.zloout = 1'b1; step("br0_t6", e);
        step("br0_back_t0", t0_exp());
        con_ff = 1'b1;
        fetch("br1", 5'(OP_BR));
        tick(); tick(); tick();
        e = '0; e.zloout = 1'b1; e.pcin = 1'b1; step("br1_t6", e);
        step("br1_back_t0", t0_exp());
        con_ff = 1'b0;

        // stop raised mid-instruction only takes effect at the boundary
        fetch("stp", 5'(OP_ADD));
        stop = 1'b1;
        e = '0; e.grb = 1'b1; e.rout = 1'b1; e.yin = 1'b1; step("stp_t3", e);
        e = '0; e.grc = 1'b1; e.rout = 1'b1; e.alu_op = ALU_ADD; e.zin = 1'b1; step("stp_t4", e);
        e = '0; e.zloout = 1'b1; e.gra = 1'b1; e.rin = 1'b1; step("stp_t5", e);
        step("pause_ctl", '0);
        check_eq("pause_run", 64'(run), 64'(0));
        tick();
        check_eq("pause_run_hold", 64'(run), 64'(0));
        stop = 1'b0;
        step("resume_t0", t0_exp());
        check_eq("resume_run", 64'(run), 64'(1));

        // undefined opcode, then a nop keeps it sticky
        fetch("ill", 5'd31);
        check_eq("ill_before", 64'(illegal), 64'(0));
        step("ill_t0", t0_exp());
        check_eq("ill_set", 64'(illegal), 64'(1));
        fetch("nop", 5'(OP_NOP));
        step("nop_t0", t0_exp());
        check_eq("ill_sticky", 64'(illegal), 64'(1));

        // halt
        fetch("hlt", 5'(OP_HALT));
        step("halt_ctl", '0);
        check_eq("halt_run", 64'(run), 64'(0));
        repeat (5) tick();
        check_eq("halt_run_hold", 64'(run), 64'(0));

        reset = 1'b1;
        #1;
        check_eq("rst2_run", 64'(run), 64'(1));
        check_eq("rst2_illegal", 64'(illegal), 64'(0));
        tick();
        reset = 1'b0;
        tick();

        // reset while a load is stalled on memory
        fetch("ld2", 5'(OP_LD));
        tick(); tick(); tick();
        step("ld2_t6", e_read);
        bus.mem_ready = 1'b0;
        tick(); tick();
        check_eq("ld2_stall_read", 64'(bus.ctl), 64'(e_read));
        reset = 1'b1;
        #1;
        check_eq("rst3_ctl", 64'(bus.ctl), 64'(0));
        check_eq("rst3_run", 64'(run), 64'(1));
        check_eq("rst3_clear", 64'(clear), 64'(0));
        bus.mem_ready = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check_eq("rst3_init_clear", 64'(clear), 64'(1));
        step("rst3_t0", t0_exp());

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
